// File: rtl/simple_deadapter.sv
// Width down-converter: one 2*WIDTH_DOUT-bit word in, two WIDTH_DOUT-bit words out,
// upper half first. A word flagged din_half emits only its upper half.
module simple_deadapter #(
  parameter int WIDTH_DOUT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din_vld,
  output logic                    din_rdy,
  input  logic [2*WIDTH_DOUT-1:0] din,
  input  logic                    din_half,
  output logic                    dout_vld,
  input  logic                    dout_rdy,
  output logic [WIDTH_DOUT-1:0]   dout,
  output logic                    dout_hi,
  output logic                    dout_last
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HI    = 2'd1,
    LO    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [2*WIDTH_DOUT-1:0] buf_q, buf_d;
  logic                    half_q, half_d;
  logic                    fire_s;
  logic                    accept_s;

  // Output decode straight from the holding register and state
  always_comb begin
    dout_vld  = 1'b0;
    dout      = '0;
    dout_hi   = 1'b0;
    dout_last = 1'b0;
    case (state_q)
      EMPTY: begin
        dout_vld = 1'b0;
      end
      HI: begin
        dout_vld  = 1'b1;
        dout      = buf_q[2*WIDTH_DOUT-1:WIDTH_DOUT];
        dout_hi   = 1'b1;
        dout_last = half_q;
      end
      LO: begin
        dout_vld  = 1'b1;
        dout      = buf_q[WIDTH_DOUT-1:0];
        dout_last = 1'b1;
      end
      default: begin
        dout_vld = 1'b0;
      end
    endcase
  end

  // Ready passes through from dout_rdy only when the final narrow word leaves,
  // so a new word can load in the same cycle without a bubble.
  assign fire_s   = dout_vld & dout_rdy;
  assign din_rdy  = ~rst & ((state_q == EMPTY) | (fire_s & dout_last));
  assign accept_s = din_vld & din_rdy;

  // Next-state and holding-register load
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    half_d  = half_q;
    if (accept_s) begin
      buf_d  = din;
      half_d = din_half;
    end else begin
      buf_d  = buf_q;
      half_d = half_q;
    end
    case (state_q)
      EMPTY: begin
        if (accept_s) state_d = HI;
        else          state_d = EMPTY;
      end
      HI: begin
        if (!fire_s)       state_d = HI;
        else if (!half_q)  state_d = LO;
        else if (accept_s) state_d = HI;
        else               state_d = EMPTY;
      end
      LO: begin
        if (!fire_s)       state_d = LO;
        else if (accept_s) state_d = HI;
        else               state_d = EMPTY;
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State and buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      buf_q   <= '0;
      half_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      half_q  <= half_d;
    end
  end

endmodule

// File: tb/tb_simple_deadapter.sv
// Directed and scoreboarded checks for simple_deadapter (WIDTH_DOUT=8).
module tb_simple_deadapter;

  logic        clk;
  logic        rst;
  logic        din_vld;
  logic        din_rdy;
  logic [15:0] din;
  logic        din_half;
  logic        dout_vld;
  logic        dout_rdy;
  logic [7:0]  dout;
  logic        dout_hi;
  logic        dout_last;

  int checks_cnt;
  int errors_cnt;

  // Pending input words {half, word} and expected outputs {hi, last, byte}
  logic [16:0] in_q[$];
  logic [9:0]  exp_q[$];

  simple_deadapter #(.WIDTH_DOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .din_vld   (din_vld),
    .din_rdy   (din_rdy),
    .din       (din),
    .din_half  (din_half),
    .dout_vld  (dout_vld),
    .dout_rdy  (dout_rdy),
    .dout      (dout),
    .dout_hi   (dout_hi),
    .dout_last (dout_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w, input logic h);
    in_q.push_back({h, w});
    exp_q.push_back({1'b1, h, w[15:8]});
    if (!h) exp_q.push_back({1'b0, 1'b1, w[7:0]});
  endtask

  task automatic run_stream(input int rdy_pct, input int vld_pct, output int cycles);
    logic       stall;
    logic       pending;
    logic [9:0] held;
    stall   = 1'b0;
    pending = 1'b0;
    held    = 10'd0;
    cycles  = 0;
    while (exp_q.size() > 0 && cycles < 20000) begin
      @(posedge clk); #1;
      if (in_q.size() > 0 && (pending || $urandom_range(99) < vld_pct)) begin
        din_vld = 1'b1;
        {din_half, din} = in_q[0];
      end else begin
        din_vld  = 1'b0;
        din      = 16'($urandom);
        din_half = 1'b0;
      end
      dout_rdy = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      cycles++;
      if (stall) check_val("stall_stable", {21'd0, dout_vld, dout_hi, dout_last, dout}, {21'd0, 1'b1, held});
      if (dout_vld && dout_rdy) begin
        if (exp_q.size() > 0) check_val("dout_word", {22'd0, dout_hi, dout_last, dout}, {22'd0, exp_q.pop_front()});
        else                  check_val("extra_word", 32'd1, 32'd0);
      end
      stall = dout_vld && !dout_rdy;
      held  = {dout_hi, dout_last, dout};
      if (din_vld && din_rdy) begin
        void'(in_q.pop_front());
        pending = 1'b0;
      end else begin
        pending = din_vld;
      end
    end
    check_val("stream_timeout", exp_q.size(), 32'd0);
    @(posedge clk); #1;
    din_vld  = 1'b0;
    dout_rdy = 1'b1;
    @(negedge clk);
    check_val("stream_drained", {31'd0, dout_vld}, 32'd0);
  endtask

  initial begin
    int         cyc;
    logic [7:0] bytes[$];
    checks_cnt = 0;
    errors_cnt = 0;
    rst      = 1'b1;
    din_vld  = 1'b0;
    din      = 16'h0000;
    din_half = 1'b0;
    dout_rdy = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_val("rst_outputs", {27'd0, din_rdy, dout_vld, dout_hi, dout_last, 1'b0}, 32'd0);
    check_val("rst_dout", {24'd0, dout}, 32'd0);

    // Single word A55A
    @(posedge clk); #1;
    rst      = 1'b0;
    din      = 16'hA55A;
    din_vld  = 1'b1;
    dout_rdy = 1'b1;
    @(negedge clk);
    check_val("idle_rdy", {30'd0, din_rdy, dout_vld}, 32'd2);
    @(posedge clk); #1;
    din_vld = 1'b0;
    din     = 16'h0000;
    @(negedge clk);
    check_val("a5_word", {20'd0, din_rdy, dout_vld, dout_hi, dout_last, dout}, {20'd0, 4'b0110, 8'hA5});
    @(posedge clk); #1;
    @(negedge clk);
    check_val("5a_word", {20'd0, din_rdy, dout_vld, dout_hi, dout_last, dout}, {20'd0, 4'b1101, 8'h5A});
    @(posedge clk); #1;
    @(negedge clk);
    check_val("single_done", {23'd0, dout_vld, dout}, 32'd0);

    // Odd tail
    in_q.push_back({1'b0, 16'h1122});
    in_q.push_back({1'b1, 16'h3300});
    exp_q.push_back({2'b10, 8'h11});
    exp_q.push_back({2'b01, 8'h22});
    exp_q.push_back({2'b11, 8'h33});
    run_stream(100, 100, cyc);
    check_val("odd_tail_cycles", cyc, 32'd4);

    // Back-to-back stream: no bubbles
    for (int i = 0; i < 512; i++) push_word(16'($urandom), 1'b0);
    run_stream(100, 100, cyc);
    check_val("b2b_cycles", cyc, 32'd1025);

    // Backpressure with input gaps
    for (int i = 0; i < 200; i++) push_word(16'($urandom), 1'b0);
    run_stream(20, 50, cyc);

    // Reset mid-word
    @(posedge clk); #1;
    din      = 16'hBEEF;
    din_half = 1'b0;
    din_vld  = 1'b1;
    dout_rdy = 1'b1;
    @(posedge clk); #1;
    din_vld = 1'b0;
    @(negedge clk);
    check_val("be_word", {21'd0, dout_vld, dout_hi, dout_last, dout}, {21'd0, 3'b110, 8'hBE});
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_a", {30'd0, dout_vld, din_rdy}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("midrst_b", {30'd0, dout_vld, din_rdy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_idle", {30'd0, dout_vld, din_rdy}, 32'd1);
    in_q.push_back({1'b0, 16'h0102});
    exp_q.push_back({2'b10, 8'h01});
    exp_q.push_back({2'b01, 8'h02});
    run_stream(100, 100, cyc);

    // Round trip: bytes paired MSB-first upstream, odd byte count ends in a half word
    for (int i = 0; i < 255; i++) bytes.push_back(8'($urandom));
    for (int i = 0; i < 255; i += 2) begin
      if (i + 1 < 255) in_q.push_back({1'b0, bytes[i], bytes[i+1]});
      else             in_q.push_back({1'b1, bytes[i], 8'($urandom)});
    end
    for (int i = 0; i < 255; i++) begin
      exp_q.push_back({(i % 2 == 0), ((i % 2 == 1) || (i == 254)), bytes[i]});
    end
    run_stream(70, 60, cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
